hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_fwd_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding selects plus registered load-use / data-memory-wait hazard FSM.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_ctrl #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            ex_rd_wren,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_rd_addr,
  input  logic [RA_W-1:0] ex_rs1_addr,
  input  logic [RA_W-1:0] ex_rs2_addr,
  input  logic [1:0]      ex_op_sel_a,
  input  logic [1:0]      ex_op_sel_b,
  input  logic            ex_brc_taken,
  input  logic            mem_rd_wren,
  input  logic            mem_is_load,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            dmem_ready,
  input  logic            wb_rd_wren,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [1:0]      fwd_rs1_brc,
  output logic [1:0]      fwd_rs2_brc,
  output logic            fwd_rs1_id,
  output logic            fwd_rs2_id,
  output logic            pc_enable,
  output logic            id_enable,
  output logic            ex_enable,
  output logic            mem_enable,
  output logic            id_flush,
  output logic            ex_flush,
  output logic [1:0]      hazard_state,
  output logic            mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state    | meaning
  // RUN      | pipeline flowing normally
  // LU_STALL | load-use bubbles still owed beyond the first
  // MEM_WAIT | frozen on a load waiting for dmem_ready
  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_LU   = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;

  localparam logic [3:0] LU_INIT   = 4'(LOAD_LAT - 1);
  localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_TRIP = 8'(MAX_WAIT - 1);

  logic [1:0] state, state_nx, eff_state;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] wcnt;
  logic       saved_lu;
  logic       freeze, lu_hazard;
  logic       mem_m1, mem_m2, wb_m1, wb_m2;

  assign mem_m1 = mem_rd_wren && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs1_addr);
  assign mem_m2 = mem_rd_wren && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs2_addr);
  assign wb_m1  = wb_rd_wren && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs1_addr);
  assign wb_m2  = wb_rd_wren && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs2_addr);

  assign fwd_rs1_brc = mem_m1 ? 2'b10 : (wb_m1 ? 2'b01 : 2'b00);
  assign fwd_rs2_brc = mem_m2 ? 2'b10 : (wb_m2 ? 2'b01 : 2'b00);
  assign fwd_a = (ex_op_sel_a == 2'b00) ? fwd_rs1_brc : ex_op_sel_a;
  assign fwd_b = (ex_op_sel_b == 2'b00) ? fwd_rs2_brc : ex_op_sel_b;

  assign fwd_rs1_id = wb_rd_wren && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr);
  assign fwd_rs2_id = wb_rd_wren && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr);

  assign lu_hazard = ex_is_load && ex_rd_wren && (ex_rd_addr != '0) &&
                     ((id_rs1_used && (ex_rd_addr == id_rs1_addr)) ||
                      (id_rs2_used && (ex_rd_addr == id_rs2_addr)));
  assign freeze = mem_is_load && !dmem_ready;

  // The cycle dmem_ready returns does the work of the interrupted state,
  // so a freeze costs exactly its own cycles and nothing more.
  assign eff_state = (state == ST_WAIT) ? (saved_lu ? ST_LU : ST_RUN) : state;

  always_comb begin
    state_nx   = ST_RUN;
    cnt_nx     = cnt;
    pc_enable  = 1'b1;
    id_enable  = 1'b1;
    ex_enable  = 1'b1;
    mem_enable = 1'b1;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    if (freeze) begin
      pc_enable  = 1'b0;
      id_enable  = 1'b0;
      ex_enable  = 1'b0;
      mem_enable = 1'b0;
      state_nx   = ST_WAIT;
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (ex_brc_taken) begin
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end else if (lu_hazard) begin
            pc_enable = 1'b0;
            id_enable = 1'b0;
            ex_flush  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nx = ST_LU;
              cnt_nx   = LU_INIT;
            end
          end
        end
        ST_LU: begin
          pc_enable = 1'b0;
          id_enable = 1'b0;
          ex_flush  = 1'b1;
          if (cnt <= 4'd1) begin
            cnt_nx = 4'd0;
          end else begin
            cnt_nx   = cnt - 4'd1;
            state_nx = ST_LU;
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
    if (i_reset) begin
      pc_enable  = 1'b1;
      id_enable  = 1'b1;
      ex_enable  = 1'b1;
      mem_enable = 1'b1;
      id_flush   = 1'b0;
      ex_flush   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_RUN;
      cnt         <= 4'd0;
      saved_lu    <= 1'b0;
      wcnt        <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (freeze && (state != ST_WAIT))
        saved_lu <= (state == ST_LU);
      if (freeze) begin
        if (wcnt != WAIT_LIM)
          wcnt <= wcnt + 8'd1;
        if (wcnt >= WAIT_TRIP)
          mem_timeout <= 1'b1;
      end else begin
        wcnt <= 8'd0;
      end
    end
  end

  assign hazard_state = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_enable && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (id_flush && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl with LOAD_LAT=3, MAX_WAIT=4.
module tb_hazard_fwd_ctrl;
  logic       i_clk, i_reset;
  logic       ex_rd_wren, ex_is_load, ex_brc_taken;
  logic [4:0] ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
  logic [1:0] ex_op_sel_a, ex_op_sel_b;
  logic       mem_rd_wren, mem_is_load, dmem_ready, wb_rd_wren;
  logic [4:0] mem_rd_addr, wb_rd_addr, id_rs1_addr, id_rs2_addr;
  logic       id_rs1_used, id_rs2_used;
  logic [1:0] fwd_a, fwd_b, fwd_rs1_brc, fwd_rs2_brc, hazard_state;
  logic       fwd_rs1_id, fwd_rs2_id, pc_enable, id_enable, ex_enable, mem_enable;
  logic       id_flush, ex_flush, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];
  logic [18:0] got, e;

  hazard_fwd_ctrl #(.RA_W(5), .LOAD_LAT(3), .MAX_WAIT(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .ex_rd_wren(ex_rd_wren), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_op_sel_a(ex_op_sel_a), .ex_op_sel_b(ex_op_sel_b), .ex_brc_taken(ex_brc_taken),
    .mem_rd_wren(mem_rd_wren), .mem_is_load(mem_is_load), .mem_rd_addr(mem_rd_addr),
    .dmem_ready(dmem_ready), .wb_rd_wren(wb_rd_wren), .wb_rd_addr(wb_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_rs1_brc(fwd_rs1_brc), .fwd_rs2_brc(fwd_rs2_brc),
    .fwd_rs1_id(fwd_rs1_id), .fwd_rs2_id(fwd_rs2_id),
    .pc_enable(pc_enable), .id_enable(id_enable), .ex_enable(ex_enable), .mem_enable(mem_enable),
    .id_flush(id_flush), .ex_flush(ex_flush), .hazard_state(hazard_state),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  // fw = {fwd_a, fwd_b, fwd_rs1_brc, fwd_rs2_brc}, idb = {rs1_id, rs2_id},
  // en = {pc, id, ex, mem}, fl = {id_flush, ex_flush}
  function automatic logic [18:0] mk(logic [7:0] fw, logic [1:0] idb, logic [3:0] en,
                                     logic [1:0] fl, logic [1:0] hs, logic to);
    return {fw, idb, en, fl, hs, to};
  endfunction

  function automatic logic [18:0] obs();
    return {fwd_a, fwd_b, fwd_rs1_brc, fwd_rs2_brc, fwd_rs1_id, fwd_rs2_id,
            pc_enable, id_enable, ex_enable, mem_enable, id_flush, ex_flush,
            hazard_state, mem_timeout};
  endfunction

  task automatic set_idle();
    ex_rd_wren = 0; ex_is_load = 0; ex_brc_taken = 0;
    ex_rd_addr = 0; ex_rs1_addr = 0; ex_rs2_addr = 0;
    ex_op_sel_a = 0; ex_op_sel_b = 0;
    mem_rd_wren = 0; mem_is_load = 0; mem_rd_addr = 0; dmem_ready = 1;
    wb_rd_wren = 0; wb_rd_addr = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_is_load = 1; ex_rd_wren = 1; ex_rd_addr = rd;
  endtask

  task automatic set_ex_bubble();
    ex_is_load = 0; ex_rd_wren = 0; ex_rd_addr = 0; ex_brc_taken = 0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        set_idle();
        i_reset = 1;
        mem_rd_wren = 1; mem_rd_addr = 5; ex_rs1_addr = 5;
        mem_is_load = 1; dmem_ready = 0;
        set_load(7); id_rs1_addr = 7; id_rs1_used = 1;
        exp_q.push_back(mk(8'b10_00_10_00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        @(posedge i_clk);
      end else begin
        next_cycle();
        i_reset = 0;
        set_idle();
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
      end
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%h exp=%h", k, got, e);
      end
      if (k == 0) begin
        checks++;
        if ({stall_cnt, flush_cnt} !== 32'h0) begin
          errors++;
          $display("FAIL reset_counters got=%h exp=0", {stall_cnt, flush_cnt});
        end
      end
    end
  endtask

  task automatic test_forward();
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      set_idle();
      case (k)
        0: begin
          mem_rd_wren = 1; mem_rd_addr = 5; wb_rd_wren = 1; wb_rd_addr = 5;
          ex_rs1_addr = 5; ex_rs2_addr = 5; ex_op_sel_b = 2'b01;
          id_rs1_addr = 5; id_rs2_addr = 3;
          exp_q.push_back(mk(8'b10_01_10_10, 2'b10, 4'hF, 2'b00, 2'b00, 1'b0));
        end
        1: begin
          mem_rd_wren = 1; wb_rd_wren = 1;
          exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        end
        2: begin
          mem_rd_addr = 5; wb_rd_wren = 1; wb_rd_addr = 5;
          ex_rs1_addr = 5; ex_rs2_addr = 6; id_rs1_addr = 4; id_rs2_addr = 5;
          exp_q.push_back(mk(8'b01_00_01_00, 2'b01, 4'hF, 2'b00, 2'b00, 1'b0));
        end
        3: begin
          mem_rd_wren = 1; mem_rd_addr = 6; wb_rd_wren = 1; wb_rd_addr = 6;
          ex_rs1_addr = 6; ex_rs2_addr = 6; ex_op_sel_a = 2'b11;
          exp_q.push_back(mk(8'b11_10_10_10, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        end
        default: begin
          ex_rs1_addr = 6; ex_op_sel_a = 2'b10; wb_rd_addr = 6; mem_rd_addr = 6;
          exp_q.push_back(mk(8'b10_00_00_00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        end
      endcase
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL forward[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) begin
        set_idle(); set_load(7); id_rs1_addr = 7; id_rs1_used = 1;
      end else begin
        set_ex_bubble();
      end
      if (k < 3)
        exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, (k == 0) ? 2'b00 : 2'b01, 1'b0));
      else
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load_use[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_no_use();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      set_idle(); set_load(7);
      id_rs1_addr = 7; id_rs1_used = 0; id_rs2_addr = 8; id_rs2_used = 1;
      exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL no_use[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      set_idle();
      if (k == 0) begin
        set_load(7); ex_brc_taken = 1; id_rs1_addr = 7; id_rs1_used = 1;
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b11, 2'b00, 1'b0));
      end else begin
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
      end
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL branch[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_freeze_stall();
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      case (k)
        0: begin
          set_idle(); set_load(7); id_rs1_addr = 7; id_rs1_used = 1;
          exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b00, 1'b0));
        end
        1: begin
          set_ex_bubble(); mem_rd_wren = 1; mem_rd_addr = 7; mem_is_load = 1; dmem_ready = 0;
          exp_q.push_back(mk(8'h00, 2'b00, 4'h0, 2'b00, 2'b01, 1'b0));
        end
        2, 3: exp_q.push_back(mk(8'h00, 2'b00, 4'h0, 2'b00, 2'b10, 1'b0));
        4: begin
          dmem_ready = 1;
          exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b10, 1'b0));
        end
        5: begin
          mem_is_load = 0; mem_rd_wren = 0; mem_rd_addr = 0;
          exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b01, 1'b0));
        end
        default: begin
          set_idle();
          exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        end
      endcase
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL freeze_stall[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      set_idle();
      if (k < 5) begin
        mem_is_load = 1; dmem_ready = 0;
        exp_q.push_back(mk(8'h00, 2'b00, 4'h0, 2'b00, (k == 0) ? 2'b00 : 2'b10, k >= 4));
      end else if (k == 5) begin
        mem_is_load = 1;
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b10, 1'b1));
      end else begin
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b1));
      end
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      if (k == 2 || k == 6) begin
        #2;
        i_reset = 1;
        exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        #1;
      end else begin
        next_cycle();
        case (k)
          0: begin
            set_idle(); mem_is_load = 1; dmem_ready = 0;
            exp_q.push_back(mk(8'h00, 2'b00, 4'h0, 2'b00, 2'b00, 1'b1));
          end
          1: exp_q.push_back(mk(8'h00, 2'b00, 4'h0, 2'b00, 2'b10, 1'b1));
          3: begin
            i_reset = 0; set_idle();
            exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
          end
          4: begin
            set_load(7); id_rs1_addr = 7; id_rs1_used = 1;
            exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b00, 1'b0));
          end
          5: begin
            set_ex_bubble();
            exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b01, 1'b0));
          end
          default: begin
            i_reset = 0;
            exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
          end
        endcase
        @(negedge i_clk);
      end
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      case (k)
        0, 4: begin
          set_idle(); set_load(9);
          id_rs1_addr = 1; id_rs1_used = 1; id_rs2_addr = 9; id_rs2_used = 1;
          exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b00, 1'b0));
        end
        3: begin
          set_idle(); ex_brc_taken = 1;
          exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b11, 2'b00, 1'b0));
        end
        7: begin
          set_idle();
          exp_q.push_back(mk(8'h00, 2'b00, 4'hF, 2'b00, 2'b00, 1'b0));
        end
        default: begin
          set_ex_bubble();
          exp_q.push_back(mk(8'h00, 2'b00, 4'b0011, 2'b01, 2'b01, 1'b0));
        end
      endcase
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  initial begin
    i_reset = 1;
    set_idle();
    test_reset();
    test_forward();
    test_load_use();
    test_no_use();
    test_branch();
    test_freeze_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
